// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops a byte, sends start, 8 data bits LSB first, optional parity, stop.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] rd_data,
  output logic       rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, FETCH = 3'd1, LOAD = 3'd2, START = 3'd3, DATA = 3'd4, STOP = 3'd5, PARITY = 3'd6
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, FETCH = 3'd1, LOAD = 3'd2, START = 3'd3, DATA = 3'd4, STOP = 3'd5
  } state_e;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt_s;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             rd_en_q, rd_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end_s;
`ifdef FIFO_UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign bit_end_s = (cnt_q == LAST_CNT);
  assign cnt_nxt_s = bit_end_s ? '0 : cnt_q + CNT_W'(1);

  // State and datapath registers; outputs are registered from next-state lookahead
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
`ifdef FIFO_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tx_en && !fifo_empty) state_d = FETCH;
        else                      state_d = IDLE;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        // rd_data is valid now, one cycle after the strobe
        shift_d = rd_data;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = ^rd_data;
`endif
        cnt_d   = '0;
        idx_d   = 3'd0;
        state_d = START;
      end
      START: begin
        cnt_d = cnt_nxt_s;
        if (bit_end_s) begin
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        cnt_d = cnt_nxt_s;
        if (bit_end_s) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        cnt_d = cnt_nxt_s;
        if (bit_end_s) state_d = STOP;
        else           state_d = PARITY;
      end
`endif
      STOP: begin
        cnt_d = cnt_nxt_s;
        if (bit_end_s && tx_en && !fifo_empty) state_d = FETCH;
        else if (bit_end_s)                    state_d = IDLE;
        else                                   state_d = STOP;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state, so the registered outputs line up with state_q
  always_comb begin
    tx_d    = 1'b1;
    rd_en_d = 1'b0;
    done_d  = 1'b0;
    busy_d  = (state_d != IDLE);
    case (state_d)
      FETCH: rd_en_d = 1'b1;
      START: tx_d    = 1'b0;
      DATA:  tx_d    = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: tx_d   = par_d;
`endif
      STOP:  done_d  = (cnt_d == LAST_CNT);
      default: tx_d  = 1'b1;
    endcase
  end

  assign tx         = tx_q;
  assign rd_en      = rd_en_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4 with a registered-read FIFO model.
module tb_fifo_uart_tx;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR   = 1'b0;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_en;
  logic       fifo_empty;
  logic [7:0] rd_data;
  logic       rd_en, tx, busy, frame_done;

  logic [7:0] fifo_mem [0:15];
  int         wr_n = 0;
  int         rd_n = 0;
  int         pops = 0;
  int         bad_pops = 0;
  int         passed = 0;
  int         total = 0;

  logic tx_log   [0:199];
  logic rd_log   [0:199];
  logic fd_log   [0:199];
  logic busy_log [0:199];

  assign fifo_empty = (wr_n == rd_n);

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .tx_en(tx_en), .fifo_empty(fifo_empty),
    .rd_data(rd_data), .rd_en(rd_en), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  // FIFO model: registered read data, valid the cycle after the strobe
  always @(posedge clk) begin
    if (rd_en === 1'b1) begin
      pops <= pops + 1;
      if (fifo_empty) begin
        bad_pops <= bad_pops + 1;
      end else begin
        rd_data <= fifo_mem[rd_n[3:0]];
        rd_n    <= rd_n + 1;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_n[3:0]] = b;
    wr_n = wr_n + 1;
  endtask

  task automatic sample(input int i);
    tx_log[i]   = tx;
    rd_log[i]   = rd_en;
    fd_log[i]   = frame_done;
    busy_log[i] = busy;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample(i);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int k);
    if (k == 0)                 return 1'b0;
    else if (k <= 8)            return d[k-1];
    else if (k == 9 && PAR)     return ^d;
    else                        return 1'b1;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    tx_en = 1'b1;
    push(8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({tx, rd_en, busy, frame_done} !== 4'b1000) begin
        $display("FAIL reset_hold[%0d]: got tx/rd_en/busy/done=%b expected 1000", i, {tx, rd_en, busy, frame_done});
      end else passed++;
    end
  endtask

  task automatic test_single();
    int cnt;
    logic ok;
    reset = 1'b1;
    capture(FRAME + 6);
    cnt = 0;
    for (int i = 0; i < FRAME + 6; i++) if (rd_log[i] === 1'b1) cnt++;
    total++;
    if (rd_log[0] !== 1'b1 || cnt != 1) begin
      $display("FAIL single_rd_en: got first=%b pulses=%0d expected first=1 pulses=1", rd_log[0], cnt);
    end else passed++;
    for (int k = 0; k < NBITS; k++) begin
      ok = 1'b1;
      for (int j = 0; j < CPB; j++) if (tx_log[2 + k*CPB + j] !== exp_bit(8'hA5, k)) ok = 1'b0;
      total++;
      if (!ok) begin
        $display("FAIL single_bit%0d: got tx=%b expected %b for 4 cycles", k, tx_log[2 + k*CPB], exp_bit(8'hA5, k));
      end else passed++;
    end
    cnt = 0;
    for (int i = 0; i < FRAME + 6; i++) if (fd_log[i] === 1'b1) cnt++;
    total++;
    if (fd_log[FRAME + 1] !== 1'b1 || cnt != 1) begin
      $display("FAIL single_frame_done: got at_end=%b pulses=%0d expected 1 and 1", fd_log[FRAME + 1], cnt);
    end else passed++;
    total++;
    if ({busy_log[FRAME + 1], busy_log[FRAME + 2]} !== 2'b10) begin
      $display("FAIL single_busy_drop: got %b expected 10", {busy_log[FRAME + 1], busy_log[FRAME + 2]});
    end else passed++;
  endtask

  task automatic test_back_to_back();
    int   p0;
    logic ok;
    int   b2;
    p0 = pops;
    b2 = FRAME + 4;
    push(8'h00);
    push(8'hFF);
    capture(2*FRAME + 8);
    total++;
    if ({fd_log[FRAME + 1], rd_log[FRAME + 2]} !== 2'b11 || rd_log[0] !== 1'b1) begin
      $display("FAIL b2b_second_pop: got done=%b rd_en_next=%b first=%b expected 1 1 1", fd_log[FRAME + 1], rd_log[FRAME + 2], rd_log[0]);
    end else passed++;
    total++;
    if ({tx_log[FRAME + 2], tx_log[FRAME + 3], tx_log[FRAME + 4]} !== 3'b110) begin
      $display("FAIL b2b_gap: got %b expected 110", {tx_log[FRAME + 2], tx_log[FRAME + 3], tx_log[FRAME + 4]});
    end else passed++;
    ok = 1'b1;
    for (int i = 0; i <= 2*FRAME + 3; i++) if (busy_log[i] !== 1'b1) ok = 1'b0;
    total++;
    if (!ok) $display("FAIL b2b_busy: got a low busy cycle expected busy high across both frames");
    else passed++;
    ok = 1'b1;
    for (int i = 2 + CPB; i < 2 + 9*CPB; i++) if (tx_log[i] !== 1'b0) ok = 1'b0;
    total++;
    if (!ok) $display("FAIL b2b_data00: got a high data bit expected all 0");
    else passed++;
    ok = 1'b1;
    for (int i = b2 + CPB; i < b2 + 9*CPB; i++) if (tx_log[i] !== 1'b1) ok = 1'b0;
    total++;
    if (!ok) $display("FAIL b2b_dataFF: got a low data bit expected all 1");
    else passed++;
    total++;
    if ({fd_log[2*FRAME + 3], busy_log[2*FRAME + 4]} !== 2'b10 || pops - p0 != 2) begin
      $display("FAIL b2b_end: got done=%b busy_after=%b pops=%0d expected 1 0 2", fd_log[2*FRAME + 3], busy_log[2*FRAME + 4], pops - p0);
    end else passed++;
  endtask

  task automatic test_empty();
    logic ok;
    int   p0;
    p0 = pops;
    tx_en = 1'b1;
    capture(20);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) if ({tx_log[i], rd_log[i], busy_log[i]} !== 3'b100) ok = 1'b0;
    total++;
    if (!ok || pops != p0 || bad_pops != 0) begin
      $display("FAIL empty_idle: got pops=%0d bad_pops=%0d line_ok=%b expected 0 0 1", pops - p0, bad_pops, ok);
    end else passed++;
  endtask

  task automatic test_disable();
    int   cnt;
    logic ok;
    push(8'h3C);
    push(8'h55);
    tx_en = 1'b1;
    for (int i = 0; i < FRAME + 21; i++) begin
      @(negedge clk);
      sample(i);
      if (i == 2 + 4*CPB + 1) tx_en = 1'b0;
    end
    cnt = 0;
    for (int i = 0; i < FRAME + 21; i++) if (rd_log[i] === 1'b1) cnt++;
    total++;
    if ({fd_log[FRAME + 1], busy_log[FRAME + 2]} !== 2'b10 || cnt != 1) begin
      $display("FAIL disable_complete: got done=%b busy_after=%b pulses=%0d expected 1 0 1", fd_log[FRAME + 1], busy_log[FRAME + 2], cnt);
    end else passed++;
    ok = 1'b1;
    for (int i = FRAME + 2; i < FRAME + 21; i++) if (tx_log[i] !== 1'b1 || busy_log[i] !== 1'b0) ok = 1'b0;
    total++;
    if (!ok) $display("FAIL disable_idle: got activity after frame expected idle line");
    else passed++;
  endtask

  task automatic test_reset_mid();
    int   cnt;
    logic ok;
    tx_en = 1'b1;
    for (int i = 0; i < 2 + 4*CPB + 2; i++) begin
      @(negedge clk);
      sample(i);
    end
    total++;
    if (tx_log[2 + 4*CPB + 1] !== 1'b0) begin
      $display("FAIL midreset_bit3: got tx=%b expected 0", tx_log[2 + 4*CPB + 1]);
    end else passed++;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({tx, rd_en, busy, frame_done} !== 4'b1000) begin
      $display("FAIL midreset_edge: got tx/rd_en/busy/done=%b expected 1000", {tx, rd_en, busy, frame_done});
    end else passed++;
    push(8'h81);
    @(negedge clk);
    reset = 1'b1;
    capture(FRAME + 4);
    cnt = 0;
    for (int i = 0; i < FRAME + 4; i++) if (rd_log[i] === 1'b1) cnt++;
    total++;
    if (rd_log[0] !== 1'b1 || cnt != 1) begin
      $display("FAIL midreset_fresh_pop: got first=%b pulses=%0d expected 1 1", rd_log[0], cnt);
    end else passed++;
    ok = 1'b1;
    for (int k = 0; k < NBITS; k++) if (tx_log[2 + k*CPB + 1] !== exp_bit(8'h81, k)) ok = 1'b0;
    total++;
    if (!ok || fd_log[FRAME + 1] !== 1'b1) begin
      $display("FAIL midreset_frame81: got bits_ok=%b done=%b expected 1 1", ok, fd_log[FRAME + 1]);
    end else passed++;
  endtask

`ifdef FIFO_UART_TX_PARITY_EN
  task automatic test_parity();
    logic ok;
    int   b2;
    b2 = FRAME + 4;
    tx_en = 1'b1;
    push(8'hA5);
    push(8'h07);
    capture(2*FRAME + 6);
    ok = 1'b1;
    for (int j = 0; j < CPB; j++) if (tx_log[2 + 9*CPB + j] !== 1'b0) ok = 1'b0;
    total++;
    if (!ok) $display("FAIL parity_A5: got tx=%b expected 0", tx_log[2 + 9*CPB]);
    else passed++;
    ok = 1'b1;
    for (int j = 0; j < CPB; j++) if (tx_log[b2 + 9*CPB + j] !== 1'b1) ok = 1'b0;
    total++;
    if (!ok) $display("FAIL parity_07: got tx=%b expected 1", tx_log[b2 + 9*CPB]);
    else passed++;
    total++;
    if ({fd_log[44], fd_log[45]} !== 2'b01) begin
      $display("FAIL parity_len44: got done[44..45]=%b expected 01", {fd_log[44], fd_log[45]});
    end else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_empty();
    test_disable();
    test_reset_mid();
`ifdef FIFO_UART_TX_PARITY_EN
    tx_en = 1'b0;
    capture(FRAME + 4);
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
